wb_daq_channel: RTL and testbench

- One DAQ acquisition channel engine; four instances sit downstream of the DAQ slave register block.
- Consumes that block's per-channel control and address registers and returns its per-channel status register.
- Buffers ADC samples in a small FIFO and drains them to memory as Wishbone master incrementing write bursts.

---
 rtl/wb_daq_channel.sv | 217 +++++++++++++++++++++
 tb/tb_wb_daq_channel.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_daq_channel.sv
// wb_daq_channel: one DAQ acquisition channel engine.
// Samples are buffered in a small FIFO and drained to memory as Wishbone
// incrementing write bursts of We = max(1, min(W, FIFO_DEPTH)) beats.
//
// Ports:
//   wb_clk, wb_rst            clock, asynchronous active-high reset
//   daq_channel_control_reg   [0] enable, [7:2] watermark W, [31:16] ring size R
//   daq_channel_address_reg   buffer base byte address ([1:0] ignored)
//   daq_channel_status_reg    [0] busy [1] empty [2] full [3] overflow
//                             [4] bus_err [15:8] level [31:16] words written
//   data_i, data_valid_i      sample input, one-cycle strobe
//   wb_m_*                    Wishbone master write port
//   interrupt                 high while overflow or bus_err is set
//
// Optional feature: define DAQ_CHANNEL_RING_EN to make the buffer a ring of
// R words (R = control[31:16], R = 0 keeps linear addressing).
module wb_daq_channel #(
    parameter int dw         = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic [dw-1:0] daq_channel_control_reg,
    input  logic [dw-1:0] daq_channel_address_reg,
    output logic [dw-1:0] daq_channel_status_reg,
    input  logic [dw-1:0] data_i,
    input  logic          data_valid_i,
    output logic [dw-1:0] wb_m_adr_o,
    output logic [dw-1:0] wb_m_dat_o,
    output logic [3:0]    wb_m_sel_o,
    output logic          wb_m_we_o,
    output logic          wb_m_cyc_o,
    output logic          wb_m_stb_o,
    output logic [2:0]    wb_m_cti_o,
    output logic [1:0]    wb_m_bte_o,
    input  logic          wb_m_ack_i,
    input  logic          wb_m_err_i,
    output logic          interrupt
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_ERROR} state_t;
    state_t state_q, state_d;

    logic            enable, en_q, en_rise;
    logic [5:0]      wm;
    logic [6:0]      we_eff;
    logic [6:0]      beats_q, beats_d;
    logic [FIFO_AW:0] wr_q, wr_d, rd_q, rd_d, level;
    logic            full, empty, push, pop, err_hit;
    logic [dw-1:0]   ptr_q, ptr_d, base_addr, status_d, status_q;
    logic [15:0]     cnt_q;
    logic            ovf_q, berr_q;
    logic [dw-1:0]   mem [FIFO_DEPTH];

    assign enable    = daq_channel_control_reg[0];
    assign wm        = daq_channel_control_reg[7:2];
    assign en_rise   = enable & ~en_q;
    assign base_addr = daq_channel_address_reg & ~dw'(3);

    assign level = wr_q - rd_q;
    assign full  = (level == (FIFO_AW+1)'(FIFO_DEPTH));
    assign empty = (level == '0);

    // Effective watermark: clamp W into 1..FIFO_DEPTH.
    always_comb begin
        if (wm == 6'd0)                        we_eff = 7'd1;
        else if (7'(wm) > 7'(FIFO_DEPTH))      we_eff = 7'(FIFO_DEPTH);
        else                                   we_eff = 7'(wm);
    end

    // err has priority over ack; the faulting word stays in the FIFO.
    assign err_hit = (state_q == S_BURST) && wb_m_err_i;
    assign pop     = (state_q == S_BURST) && wb_m_ack_i && !wb_m_err_i;
    // A start flushes the FIFO, so a sample arriving with it always fits.
    assign push    = data_valid_i && enable && (!full || pop || en_rise);

    always_comb begin
        wr_d = wr_q + (FIFO_AW+1)'(push);
        rd_d = rd_q + (FIFO_AW+1)'(pop);
        if (en_rise) begin
            wr_d = (FIFO_AW+1)'(push);
            rd_d = '0;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (push) mem[en_rise ? '0 : wr_q[FIFO_AW-1:0]] <= data_i;
    end

    // Address pointer next state (optionally wrapping to base as a ring).
`ifdef DAQ_CHANNEL_RING_EN
    logic [15:0]   ring_r, rcnt_q, rcnt_d;
    logic [dw-1:0] rbase_q;
    logic          unused_bits;
    assign ring_r      = daq_channel_control_reg[31:16];
    assign unused_bits = ^{daq_channel_control_reg[15:8], daq_channel_control_reg[1],
                           daq_channel_address_reg[1:0]};

    always_comb begin
        ptr_d  = ptr_q;
        rcnt_d = rcnt_q;
        if (en_rise) begin
            ptr_d  = base_addr;
            rcnt_d = '0;
        end else if (pop) begin
            if (ring_r != 16'd0 && rcnt_q + 16'd1 == ring_r) begin
                ptr_d  = rbase_q;
                rcnt_d = '0;
            end else begin
                ptr_d  = ptr_q + dw'(4);
                rcnt_d = rcnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            rcnt_q  <= '0;
            rbase_q <= '0;
        end else begin
            rcnt_q <= rcnt_d;
            if (en_rise) rbase_q <= base_addr;
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ^{daq_channel_control_reg[31:8], daq_channel_control_reg[1],
                           daq_channel_address_reg[1:0]};

    always_comb begin
        ptr_d = ptr_q;
        if (en_rise)  ptr_d = base_addr;
        else if (pop) ptr_d = ptr_q + dw'(4);
    end
`endif

    // FSM next state.
    always_comb begin
        state_d = state_q;
        beats_d = beats_q;
        case (state_q)
            S_IDLE:  if (en_rise) state_d = S_WAIT;
            S_WAIT: begin
                if (!enable) state_d = S_IDLE;
                else if (7'(level) >= we_eff) begin
                    beats_d = we_eff;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (err_hit) state_d = S_ERROR;
                else if (pop) begin
                    beats_d = beats_q - 7'd1;
                    // A disable mid-burst only takes effect once the burst ends.
                    if (beats_q == 7'd1) state_d = enable ? S_WAIT : S_IDLE;
                end
            end
            S_ERROR: if (!enable) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        status_d         = '0;
        status_d[0]      = (state_q != S_IDLE);
        status_d[1]      = empty;
        status_d[2]      = full;
        status_d[3]      = ovf_q;
        status_d[4]      = berr_q;
        status_d[15:8]   = 8'(level);
        status_d[31:16]  = cnt_q;
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q  <= S_IDLE;
            beats_q  <= '0;
            en_q     <= 1'b0;
            wr_q     <= '0;
            rd_q     <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            berr_q   <= 1'b0;
            status_q <= dw'(2);
        end else begin
            state_q  <= state_d;
            beats_q  <= beats_d;
            en_q     <= enable;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            ptr_q    <= ptr_d;
            status_q <= status_d;
            if (en_rise)                        cnt_q <= '0;
            else if (pop && cnt_q != 16'hFFFF)  cnt_q <= cnt_q + 16'd1;
            if (en_rise)                            ovf_q <= 1'b0;
            else if (data_valid_i && enable && !push) ovf_q <= 1'b1;
            if (en_rise)      berr_q <= 1'b0;
            else if (err_hit) berr_q <= 1'b1;
        end
    end

    // Bus outputs decode straight from registered state, so reset drops them at once.
    assign wb_m_cyc_o = (state_q == S_BURST);
    assign wb_m_stb_o = wb_m_cyc_o;
    assign wb_m_we_o  = wb_m_cyc_o;
    assign wb_m_sel_o = wb_m_cyc_o ? 4'hF : 4'h0;
    assign wb_m_adr_o = wb_m_cyc_o ? ptr_q : '0;
    assign wb_m_dat_o = wb_m_cyc_o ? mem[rd_q[FIFO_AW-1:0]] : '0;
    assign wb_m_cti_o = !wb_m_cyc_o ? 3'b000 : (beats_q == 7'd1) ? 3'b111 : 3'b010;
    assign wb_m_bte_o = 2'b00;

    assign daq_channel_status_reg = status_q;
    assign interrupt              = ovf_q | berr_q;

endmodule

// File: tb/tb_wb_daq_channel.sv
module tb_wb_daq_channel;
    logic        wb_clk = 1'b0, wb_rst = 1'b1;
    logic [31:0] ctrl, addr, status, data, adr, dat;
    logic        valid, we, cyc, stb, ack, err, irq;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack_en, err_arm;
    int          err_idx, burst_beat;
    int          n_cmp = 0, n_err = 0;

    wb_daq_channel #(.dw(32), .FIFO_DEPTH(8), .FIFO_AW(3)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .daq_channel_control_reg(ctrl), .daq_channel_address_reg(addr),
        .daq_channel_status_reg(status), .data_i(data), .data_valid_i(valid),
        .wb_m_adr_o(adr), .wb_m_dat_o(dat), .wb_m_sel_o(sel), .wb_m_we_o(we),
        .wb_m_cyc_o(cyc), .wb_m_stb_o(stb), .wb_m_cti_o(cti), .wb_m_bte_o(bte),
        .wb_m_ack_i(ack), .wb_m_err_i(err), .interrupt(irq)
    );

    always #5 wb_clk = ~wb_clk;

    // Slave model: zero-wait ack when enabled, optional error on a chosen beat.
    assign err = err_arm && cyc && stb && (burst_beat == err_idx);
    assign ack = ack_en && cyc && stb && !err;

    always @(posedge wb_clk or posedge wb_rst)
        if (wb_rst)   burst_beat <= 0;
        else if (!cyc) burst_beat <= 0;
        else if (ack)  burst_beat <= burst_beat + 1;

    typedef struct { logic [31:0] a; logic [31:0] d; logic [2:0] c; } beat_t;
    beat_t       beats[$];
    logic [31:0] sq[$];

    always @(negedge wb_clk)
        if (!wb_rst && cyc && stb && ack) beats.push_back('{adr, dat, cti});

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc_n(input int n);
        repeat (n) @(negedge wb_clk);
    endtask

    task automatic start(input logic [5:0] w, input logic [15:0] r, input logic [31:0] base);
        @(negedge wb_clk);
        ctrl = {r, 8'h00, w, 2'b00};
        cyc_n(2);
        addr = base;
        ctrl[0] = 1'b1;
        beats.delete();
        sq.delete();
    endtask

    task automatic push(input logic [31:0] d);
        @(negedge wb_clk);
        data = d; valid = 1'b1;
        sq.push_back(d);
        @(negedge wb_clk);
        valid = 1'b0;
    endtask

    task automatic wait_cyc(input string nm);
        for (int k = 0; k < 100 && !cyc; k++) @(negedge wb_clk);
        if (!cyc) chk({nm, "_timeout"}, 0, 1);
    endtask

    // Reference: every accepted sample goes out in order at base+4i; only
    // whole groups of We leave the FIFO; each group ends with cti 111.
    task automatic check_linear(input string nm, input logic [5:0] w, input logic [31:0] base,
                                output logic [31:0] exp_st);
        int we_e, nw, lvl;
        logic [31:0] ea;
        we_e = (w == 0) ? 1 : (w > 8 ? 8 : int'(w));
        nw   = (sq.size() / we_e) * we_e;
        lvl  = sq.size() - nw;
        chk({nm, "_count"}, beats.size(), nw);
        for (int i = 0; i < nw && i < beats.size(); i++) begin
            ea = (base & 32'hFFFF_FFFC) + 32'(4 * i);
            chk({nm, "_adr_dat"}, {beats[i].a, beats[i].d}, {ea, sq[i]});
            chk({nm, "_cti"}, beats[i].c, ((i % we_e) == we_e - 1) ? 3'b111 : 3'b010);
        end
        exp_st = {16'(nw), 8'(lvl), 3'b000, 1'b0, 1'b0, lvl == 8, lvl == 0, 1'b1};
    endtask

    typedef struct {
        logic [31:0] base; logic [5:0] w; int n; logic [31:0] d0;
        logic [15:0] words; logic [7:0] lvl;
    } vec_t;
    vec_t tbl[5];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] est;
        logic [31:0] ring_a[6];
        tbl[0] = '{32'h0000_1000, 6'd3,  6, 32'hA0, 16'd6, 8'd0};
        tbl[1] = '{32'h0000_3000, 6'd0,  3, 32'h10, 16'd3, 8'd0};
        tbl[2] = '{32'h0000_4000, 6'd63, 8, 32'h20, 16'd8, 8'd0};
        tbl[3] = '{32'h0000_5002, 6'd5,  7, 32'h30, 16'd5, 8'd2};
        tbl[4] = '{32'hFFFF_FFF8, 6'd2,  4, 32'h40, 16'd4, 8'd0};

        ctrl = 0; addr = 0; data = 0; valid = 0;
        ack_en = 1; err_arm = 0; err_idx = 0;

        #12;
        chk("rst_bus", {sel, we, cyc, stb, cti, bte}, 0);
        chk("rst_adr_dat", {adr, dat}, 0);
        chk("rst_status", status, 32'h2);
        chk("rst_irq", irq, 0);
        @(negedge wb_clk) wb_rst = 0;

        // Table-driven linear bursts.
        for (int t = 0; t < 5; t++) begin
            start(tbl[t].w, 16'd0, tbl[t].base);
            for (int k = 0; k < tbl[t].n; k++) push(tbl[t].d0 + 32'(k));
            cyc_n(40);
            check_linear("tbl", tbl[t].w, tbl[t].base, est);
            chk("tbl_status", status, {tbl[t].words, tbl[t].lvl, 3'b000, 2'b00,
                                       tbl[t].lvl == 8, tbl[t].lvl == 0, 1'b1});
            chk("tbl_irq", irq, 0);
        end

        // Overflow with ack withheld; restart clears it.
        start(6'd8, 16'd0, 32'h7000);
        ack_en = 0;
        for (int k = 0; k < 9; k++) push(32'hB0 + 32'(k));
        cyc_n(3);
        chk("ovf_status", status, 32'h0000_080D);
        chk("ovf_irq", irq, 1);
        ack_en = 1;
        cyc_n(20);
        ctrl[0] = 0; cyc_n(2);
        ctrl[0] = 1; cyc_n(3);
        chk("ovf_clear_status", status, 32'h0000_0003);
        chk("ovf_clear_irq", irq, 0);

        // Bus error on the second beat.
        start(6'd3, 16'd0, 32'h2000);
        err_arm = 1; err_idx = 1;
        for (int k = 0; k < 3; k++) push(32'hC0 + 32'(k));
        for (int k = 0; k < 100 && !(cyc && err); k++) @(negedge wb_clk);
        chk("err_seen", cyc && err, 1);
        @(negedge wb_clk);
        chk("err_cyc_drop", cyc, 0);
        cyc_n(2);
        chk("err_status", status, 32'h0001_0211);
        chk("err_irq", irq, 1);
        chk("err_beats", beats.size(), 1);
        if (beats.size() > 0) chk("err_beat0", {beats[0].a, beats[0].d}, {32'h2000, 32'hC0});
        err_arm = 0;
        ctrl[0] = 0; cyc_n(3);
        chk("err_idle_busy", status[0], 0);
        ctrl[0] = 1;
        beats.delete(); sq.delete();
        for (int k = 0; k < 3; k++) push(32'hD0 + 32'(k));
        cyc_n(40);
        check_linear("err_restart", 6'd3, 32'h2000, est);
        chk("err_restart_status", status, est);

        // Disable during the first beat: burst still completes.
        start(6'd3, 16'd0, 32'h6000);
        for (int k = 0; k < 3; k++) push(32'hE0 + 32'(k));
        wait_cyc("dis");
        ctrl[0] = 0;
        cyc_n(40);
        check_linear("dis", 6'd3, 32'h6000, est);
        chk("dis_status", status, 32'h0003_0002);

        // Reset asserted mid-burst.
        start(6'd3, 16'd0, 32'h6100);
        ack_en = 0;
        for (int k = 0; k < 3; k++) push(32'hF0 + 32'(k));
        wait_cyc("rst_mid");
        wb_rst = 1;
        #1;
        chk("rst_mid_bus", {sel, we, cyc, stb, cti, bte}, 0);
        chk("rst_mid_adr_dat", {adr, dat}, 0);
        chk("rst_mid_status", status, 32'h2);
        chk("rst_mid_irq", irq, 0);
        @(negedge wb_clk) wb_rst = 0;
        ack_en = 1;

`ifdef DAQ_CHANNEL_RING_EN
        ring_a = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h100, 32'h104};
        start(6'd3, 16'd4, 32'h100);
        for (int k = 0; k < 6; k++) push(32'hA0 + 32'(k));
        cyc_n(40);
        chk("ring_count", beats.size(), 6);
        for (int i = 0; i < 6 && i < beats.size(); i++) begin
            chk("ring_adr_dat", {beats[i].a, beats[i].d}, {ring_a[i], sq[i]});
            chk("ring_cti", beats[i].c, (i % 3 == 2) ? 3'b111 : 3'b010);
        end
        chk("ring_status", status, 32'h0006_0003);
`else
        ring_a = '{default: 32'h0};
`endif

        // Randomized linear runs against the reference.
        for (int r = 0; r < 6; r++) begin
            logic [5:0]  w;
            logic [31:0] b;
            int          n;
            w = 6'($urandom_range(0, 10));
            b = $urandom;
            n = $urandom_range(1, 20);
            start(w, 16'd0, b);
            for (int k = 0; k < n; k++) begin
                push($urandom);
                cyc_n($urandom_range(0, 2));
            end
            cyc_n(40);
            check_linear("rnd", w, b, est);
            chk("rnd_status", status, est);
            chk("rnd_irq", irq, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
